// File: rtl/core_reset_sequencer.sv
// core_reset_sequencer
//   Turns the board reset pin into the ordered reset release for the processor core.
//   The sequence is:
//     1. Synchronise reset deassertion.
//     2. Hold the core in reset for a fixed settle time.
//     3. Walk the register-file clear port once over every entry.
//     4. Release the core into RUN.
//   A retired halt instruction parks the core in HALTED. A soft-reset pulse restarts the
//   sequence from the hold phase without touching the pin. run_cycles counts cycles spent
//   in RUN and saturates at all-ones.
//
// Ports
//   clk           in   1       system clock, rising edge
//   rst           in   1       asynchronous active-low reset
//   halt_req      in   1       halt instruction retired (honoured in RUN only)
//   soft_rst_req  in   1       one-cycle pulse, restart from the hold phase
//   core_rst      out  1       active-high core reset, low only in RUN and HALTED
//   rf_clr_we     out  1       register-file clear write enable
//   rf_clr_addr   out  ADDR_W  register-file clear address
//   run           out  1       core may fetch/execute
//   halted        out  1       core is halted
//   run_cycles    out  CNT_W   cycles spent in RUN since the last (soft) reset
module core_reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int REG_COUNT   = 8,
  parameter int ADDR_W      = 3,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_req,
  input  logic              soft_rst_req,
  output logic              core_rst,
  output logic              rf_clr_we,
  output logic [ADDR_W-1:0] rf_clr_addr,
  output logic              run,
  output logic              halted,
  output logic [CNT_W-1:0]  run_cycles
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(REG_COUNT - 1);

  typedef enum logic [2:0] {
    S_RESET,
    S_HOLD,
    S_INIT,
    S_RUN,
    S_HALTED
  } state_t;

  state_t                 state;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   rst_sync;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Reset synchroniser: assertion is immediate, release ripples through the chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync = sync_p0[SYNC_STAGES-1];

  // Sequencer: every output is registered alongside the state it belongs to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_RESET;
      hold_cnt    <= '0;
      rf_clr_addr <= '0;
      run_cycles  <= '0;
      core_rst    <= 1'b1;
      rf_clr_we   <= 1'b0;
      run         <= 1'b0;
      halted      <= 1'b0;
    end else if (state == S_RESET) begin
      // Soft reset and halt are meaningless until the pin release has been synchronised.
      if (rst_sync) begin
        state    <= S_HOLD;
        hold_cnt <= '0;
      end
    end else if (soft_rst_req) begin
      // Soft reset outranks a simultaneous halt request.
      state       <= S_HOLD;
      hold_cnt    <= '0;
      rf_clr_addr <= '0;
      run_cycles  <= '0;
      core_rst    <= 1'b1;
      rf_clr_we   <= 1'b0;
      run         <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        S_HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST) begin
            state       <= S_INIT;
            rf_clr_addr <= '0;
            rf_clr_we   <= 1'b1;
          end
        end
        S_INIT: begin
          if (rf_clr_addr == ADDR_LAST) begin
            state       <= S_RUN;
            rf_clr_addr <= '0;
            rf_clr_we   <= 1'b0;
            core_rst    <= 1'b0;
            run         <= 1'b1;
          end else begin
            rf_clr_addr <= rf_clr_addr + 1'b1;
          end
        end
        S_RUN: begin
          // The edge that leaves RUN for HALTED is still a RUN cycle and is counted.
          run_cycles <= sat_inc(run_cycles);
          if (halt_req) begin
            state  <= S_HALTED;
            run    <= 1'b0;
            halted <= 1'b1;
          end
        end
        S_HALTED: begin
          // Parked until a soft reset or pin reset.
        end
        default: begin
          state <= S_RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_reset_sequencer.sv
module tb_core_reset_sequencer;

  localparam int SYNC = 2;
  localparam int HOLD = 4;
  localparam int REGS = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic halt_req = 1'b0;
  logic soft_rst_req = 1'b0;

  logic        core_rst, rf_clr_we, run, halted;
  logic [2:0]  rf_clr_addr;
  logic [15:0] run_cycles;

  logic        core_rst4, rf_clr_we4, run4, halted4;
  logic [2:0]  rf_clr_addr4;
  logic [3:0]  run_cycles4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  core_reset_sequencer dut (
    .clk(clk), .rst(rst), .halt_req(halt_req), .soft_rst_req(soft_rst_req),
    .core_rst(core_rst), .rf_clr_we(rf_clr_we), .rf_clr_addr(rf_clr_addr),
    .run(run), .halted(halted), .run_cycles(run_cycles)
  );

  core_reset_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .halt_req(halt_req), .soft_rst_req(soft_rst_req),
    .core_rst(core_rst4), .rf_clr_we(rf_clr_we4), .rf_clr_addr(rf_clr_addr4),
    .run(run4), .halted(halted4), .run_cycles(run_cycles4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a timeline measured in edges since the sequence origin.
  typedef struct {
    logic        core_rst;
    logic        we;
    logic [2:0]  addr;
    logic        run;
    logic        halted;
    logic [15:0] cyc;
    logic [3:0]  cyc4;
  } exp_t;

  exp_t q[$];
  bit   m_active = 0;
  int   m_rel = 0;
  int   m_t = 0;
  bit   m_halt = 0;
  int   m_cnt = 0;

  function automatic exp_t predict();
    exp_t e;
    e.core_rst = 1'b1; e.we = 1'b0; e.addr = 3'd0; e.run = 1'b0; e.halted = 1'b0;
    e.cyc  = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
    e.cyc4 = (m_cnt > 15) ? 4'hF : 4'(m_cnt);
    if (m_active) begin
      if (m_t >= HOLD && m_t < HOLD + REGS) begin
        e.we = 1'b1;
        e.addr = 3'(m_t - HOLD);
      end else if (m_t >= HOLD + REGS) begin
        e.core_rst = 1'b0;
        e.run = !m_halt;
        e.halted = m_halt;
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_active = 0; m_rel = 0; m_t = 0; m_halt = 0; m_cnt = 0;
    end else if (!m_active) begin
      m_rel++;
      if (m_rel == SYNC + 1) begin
        m_active = 1;
        m_t = 0;
      end
    end else if (soft_rst_req) begin
      m_t = 0; m_halt = 0; m_cnt = 0;
    end else if (m_t < HOLD + REGS) begin
      m_t++;
    end else if (!m_halt) begin
      m_cnt++;
      if (halt_req) m_halt = 1;
    end
    q.push_back(predict());
  end

  // Monitor: outputs are presented every cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("core_rst",    32'(core_rst),    32'(e.core_rst));
      chk("rf_clr_we",   32'(rf_clr_we),   32'(e.we));
      chk("rf_clr_addr", 32'(rf_clr_addr), 32'(e.addr));
      chk("run",         32'(run),         32'(e.run));
      chk("halted",      32'(halted),      32'(e.halted));
      chk("run_cycles",  32'(run_cycles),  32'(e.cyc));
      chk("core_rst_w4", 32'(core_rst4),   32'(e.core_rst));
      chk("run_cycles_w4", 32'(run_cycles4), 32'(e.cyc4));
    end
  end

  task automatic drive(input logic r, input logic h, input logic s);
    @(negedge clk);
    #1;
    rst = r;
    halt_req = h;
    soft_rst_req = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    bit found;
    // Power-up
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0);
    idle(15 + 10);
    // Halt ten cycles into RUN, then sit halted
    drive(1'b1, 1'b1, 1'b0);
    idle(20);
    // Soft reset out of HALTED
    drive(1'b1, 1'b0, 1'b1);
    idle(16);
    // Halt and soft reset together in RUN
    drive(1'b1, 1'b1, 1'b1);
    // Halt while holding: ignored
    drive(1'b1, 1'b1, 1'b0);
    // Find the INIT cycle with address 3, then pull the pin mid-cycle
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (rf_clr_we === 1'b1 && rf_clr_addr === 3'd3) found = 1;
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("FAIL init_addr3_wait: got timeout, expected rf_clr_addr=3 within 40 cycles");
    end
    #1;
    rst = 1'b0;
    #1;
    chk("async_core_rst",   32'(core_rst),    32'd1);
    chk("async_rf_clr_we",  32'(rf_clr_we),   32'd0);
    chk("async_rf_clr_addr", 32'(rf_clr_addr), 32'd0);
    chk("async_run",        32'(run),         32'd0);
    chk("async_halted",     32'(halted),      32'd0);
    chk("async_run_cycles", 32'(run_cycles),  32'd0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0);
    // Full sequence again, then a long run that saturates the narrow counter
    idle(15 + 25);
    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        int n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++)
          drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        drive(1'b1, 1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 59) == 0));
      end
    end
    idle(3);
    @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
